// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the time-multiplexed FIR scheduler.
// saturate() is only referenced when FIR_SAT_EN is defined.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NTAPS_DEF = 6;
  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 16;
  localparam int SHIFT_DEF = 15;

  // Accumulator is wide enough that NTAPS full products cannot overflow it.
  function automatic int accWidth(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiplier feeding an accumulator; the shared datapath
// that the scheduler steps through one tap per cycle.
module fir_mac_unit #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 35
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 mul_en_i,
  input  logic                 add_en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [CW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [DW+CW-1:0] prod_q;
  logic signed [AW-1:0]    acc_q;

  // The accumulator adds the product registered on the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) prod_q <= a_i * b_i;
      if (clear_i) acc_q <= '0;
      else if (add_en_i) acc_q <= acc_q + AW'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Sequences one NTAPS-tap FIR evaluation on a single shared multiply/accumulate unit.
// Define FIR_SAT_EN to clamp the result instead of truncating it.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  localparam int AddrW = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NTAPS*DW-1:0]   in_data_i,
  input  logic                  coef_we_i,
  input  logic [AddrW-1:0]      coef_addr_i,
  input  logic signed [CW-1:0]  coef_wdata_i,
  output logic                  coef_err_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic signed [DW-1:0]  out_data_o,
  output logic                  busy_o
);

  localparam int AW = accWidth(DW, CW, NTAPS);
  localparam logic [AddrW:0]   NTapsW = NTAPS[AddrW:0];
  localparam logic [AddrW-1:0] LastK  = AddrW'(NTAPS - 1);

  state_e               state_q, state_d;
  logic [AddrW-1:0]     k_q, k_d;
  logic signed [DW-1:0] samp_q [NTAPS];
  logic signed [CW-1:0] coef_q [NTAPS];
  logic                 coef_err_q;
  logic                 accept, coef_ok;
  logic                 clear, mul_en, add_en;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] r;
  logic signed [DW-1:0] res;

  assign accept  = (state_q == IDLE) && in_valid_i;
  assign coef_ok = coef_we_i && (state_q == IDLE) && ({1'b0, coef_addr_i} < NTapsW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      coef_err_q <= coef_we_i && !coef_ok;
    end
  end

  // A write on the accept edge lands before the first MAC cycle reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        samp_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < NTAPS; i++) samp_q[i] <= in_data_i[i*DW +: DW];
      end
      if (coef_ok) coef_q[coef_addr_i] <= coef_wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    clear   = 1'b0;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = MAC;
          k_d     = '0;
          clear   = 1'b1;
        end
      end
      MAC: begin
        mul_en = 1'b1;
        add_en = (k_q != '0);
        if (k_q == LastK) state_d = DRAIN;
        else k_d = k_q + 1'b1;
      end
      DRAIN: begin
        add_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fir_mac_unit #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .mul_en_i (mul_en),
    .add_en_i (add_en),
    .a_i      (samp_q[k_q]),
    .b_i      (coef_q[k_q]),
    .acc_o    (acc)
  );

  assign r = acc >>> SHIFT;

`ifdef FIR_SAT_EN
  logic signed [63:0] sat_v;
  assign sat_v = saturate(64'(r), DW);
  assign res   = sat_v[DW-1:0];
`else
  assign res = r[DW-1:0];
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = (state_q == DONE) ? res : '0;
  assign coef_err_o  = coef_err_q;

endmodule
